// File: rtl/aes_pkg.sv
// Shared widths, round-mode codes and sequencer state encoding for the AES decrypt path.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES_KEY_W = 128;

  localparam logic [1:0] RM_ARK      = 2'd0;
  localparam logic [1:0] RM_INV      = 2'd1;
  localparam logic [1:0] RM_INV_LAST = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEYGEN,
    ST_ROUND,
    ST_OUT
  } dec_state_t;

endpackage

// File: rtl/aes_dec_step_ctr.sv
// Round-step / hold-cycle counters with registered key index and round-mode decode.
module aes_dec_step_ctr
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS   = 10,
  parameter int unsigned ROUND_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       run,
  output logic       cyc_last,
  output logic       step_last,
  output logic [3:0] key_idx,
  output logic [1:0] rnd_mode
);

  logic [3:0] r_q;
  logic [3:0] c_q;
  logic [3:0] r_nxt;

  assign cyc_last  = (c_q == 4'(ROUND_CYCLES - 1));
  assign step_last = (r_q == 4'(NUM_ROUNDS));
  assign r_nxt     = r_q + 4'd1;

  // The decode is loaded one step ahead so key_idx/rnd_mode never glitch mid-step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q      <= '0;
      c_q      <= '0;
      key_idx  <= '0;
      rnd_mode <= RM_ARK;
    end else if (start) begin
      r_q      <= '0;
      c_q      <= '0;
      key_idx  <= 4'(NUM_ROUNDS);
      rnd_mode <= RM_ARK;
    end else if (run) begin
      if (cyc_last) begin
        c_q <= '0;
        if (!step_last) begin
          r_q      <= r_nxt;
          key_idx  <= 4'(NUM_ROUNDS) - r_nxt;
          rnd_mode <= (r_nxt == 4'(NUM_ROUNDS)) ? RM_INV_LAST : RM_INV;
        end
      end else begin
        c_q <= c_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/aes_dec_sequencer.sv
// Iterative AES-128 decrypt controller: latches a request, runs key expansion on a
// cache miss, then drives the shared inverse-round unit through all round steps.
module aes_dec_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS   = 10,
  parameter int unsigned ROUND_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] ciphertext,
  input  logic [AES_KEY_W-1:0] key,
  output logic                 key_start,
  input  logic                 key_busy_done,
  output logic [AES_KEY_W-1:0] key_q,
  output logic [3:0]           key_idx,
  input  logic [AES_KEY_W-1:0] round_key,
  output logic [AES_BLK_W-1:0] rnd_state,
  output logic [AES_KEY_W-1:0] rnd_key,
  output logic [1:0]           rnd_mode,
  input  logic [AES_BLK_W-1:0] rnd_result,
  output logic [AES_BLK_W-1:0] plaintext,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 done
);

  dec_state_t state_q;
  dec_state_t state_d;

  logic key_cache_vld;
  logic kg_first;
  logic cache_hit;
  logic accept;
  logic ctr_start;
  logic ctr_run;
  logic cyc_last;
  logic step_last;

  assign cache_hit = key_cache_vld && (key == key_q);
  assign accept    = (state_q == ST_IDLE) && in_valid && !abort;
  assign ctr_start = (state_d == ST_ROUND) && (state_q != ST_ROUND);
  assign ctr_run   = (state_q == ST_ROUND) && !abort;

  aes_dec_step_ctr #(
    .NUM_ROUNDS   (NUM_ROUNDS),
    .ROUND_CYCLES (ROUND_CYCLES)
  ) u_step_ctr (
    .clk       (clk),
    .rst       (rst),
    .start     (ctr_start),
    .run       (ctr_run),
    .cyc_last  (cyc_last),
    .step_last (step_last),
    .key_idx   (key_idx),
    .rnd_mode  (rnd_mode)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (in_valid) state_d = cache_hit ? ST_ROUND : ST_KEYGEN;
        ST_KEYGEN: if (key_busy_done && !kg_first) state_d = ST_ROUND;
        ST_ROUND:  if (cyc_last && step_last) state_d = ST_OUT;
        ST_OUT:    if (out_ready) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // in_ready is qualified by rst so every output reads 0 while reset is held.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && rst;
    key_start = (state_q == ST_KEYGEN) && kg_first;
    out_valid = (state_q == ST_OUT);
    done      = out_valid;
    rnd_key   = round_key;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rnd_state     <= '0;
      plaintext     <= '0;
      key_q         <= '0;
      key_cache_vld <= 1'b0;
      kg_first      <= 1'b0;
    end else begin
      kg_first <= (state_d == ST_KEYGEN) && (state_q != ST_KEYGEN);
      if (accept) begin
        rnd_state <= ciphertext;
        if (!cache_hit) begin
          key_q         <= key;
          key_cache_vld <= 1'b0;
        end
      end
      // An aborted expansion leaves the key store partially written.
      if (state_q == ST_KEYGEN) begin
        if (abort)                             key_cache_vld <= 1'b0;
        else if (key_busy_done && !kg_first)   key_cache_vld <= 1'b1;
      end
      if (ctr_run && cyc_last) begin
        rnd_state <= rnd_result;
        if (step_last) plaintext <= rnd_result;
      end
    end
  end

endmodule

// File: tb/tb_aes_dec_sequencer.sv
// Bench for aes_dec_sequencer: behavioural AES round/key units around two instances
// (ROUND_CYCLES 1 and 3), directed scenarios followed by random jobs.
module tb_aes_dec_sequencer;

  localparam int NR = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         abort [2];
  logic         in_valid [2];
  logic         out_ready [2];
  logic         key_busy_done [2];
  logic [127:0] ciphertext [2];
  logic [127:0] key [2];
  logic [127:0] round_key [2];
  logic [127:0] rnd_result [2];
  logic         in_ready [2];
  logic         key_start [2];
  logic         out_valid [2];
  logic         done [2];
  logic [127:0] key_q [2];
  logic [127:0] rnd_state [2];
  logic [127:0] rnd_key [2];
  logic [127:0] plaintext [2];
  logic [3:0]   key_idx [2];
  logic [1:0]   rnd_mode [2];

  logic [7:0] sbox [256];
  logic [7:0] isbox [256];

  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x, input bit inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inv ? isbox[x[127-8*i -: 8]] : sbox[x[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] x, input bit inv);
    logic [127:0] r;
    int src;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) begin
        src = inv ? (c - rw + 4) % 4 : (c + rw) % 4;
        r[127-8*(4*c+rw) -: 8] = x[127-8*(4*src+rw) -: 8];
      end
    return r;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] x, input logic [31:0] coefs);
    logic [127:0] r;
    logic [7:0]   acc;
    int           m;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) begin
          m   = (j - rw + 4) % 4;
          acc = acc ^ gmul(coefs[31-8*m -: 8], x[127-8*(4*c+j) -: 8]);
        end
        r[127-8*(4*c+rw) -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] rkey(input logic [127:0] k, input int idx);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    if (idx > NR) return '0;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [127:0] k);
    logic [127:0] s;
    s = p ^ rkey(k, 0);
    for (int r = 1; r <= NR; r++) begin
      s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      if (r < NR) s = mix(s, 32'h02030101);
      s = s ^ rkey(k, r);
    end
    return s;
  endfunction

  function automatic logic [127:0] inv_rnd(input logic [127:0] s, input logic [127:0] k,
                                           input logic [1:0] m);
    case (m)
      2'd0:    return s ^ k;
      2'd1:    return mix(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k, 32'h0e0b0d09);
      2'd2:    return sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
      default: return s;
    endcase
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int rc_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    logic kbd;
    int   kcnt;
    assign round_key[g]     = rkey(key_q[g], int'(key_idx[g]));
    assign rnd_result[g]    = inv_rnd(rnd_state[g], rnd_key[g], rnd_mode[g]);
    assign key_busy_done[g] = kbd;

    // Key unit: done rises 4 cycles after key_start and stays high until the next start.
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        kbd  <= 1'b0;
        kcnt <= 0;
      end else if (key_start[g]) begin
        kbd  <= 1'b0;
        kcnt <= 3;
      end else if (kcnt != 0) begin
        kcnt <= kcnt - 1;
        if (kcnt == 1) kbd <= 1'b1;
      end
    end

    aes_dec_sequencer #(
      .NUM_ROUNDS   (NR),
      .ROUND_CYCLES ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .abort         (abort[g]),
      .in_valid      (in_valid[g]),
      .in_ready      (in_ready[g]),
      .ciphertext    (ciphertext[g]),
      .key           (key[g]),
      .key_start     (key_start[g]),
      .key_busy_done (key_busy_done[g]),
      .key_q         (key_q[g]),
      .key_idx       (key_idx[g]),
      .round_key     (round_key[g]),
      .rnd_state     (rnd_state[g]),
      .rnd_key       (rnd_key[g]),
      .rnd_mode      (rnd_mode[g]),
      .rnd_result    (rnd_result[g]),
      .plaintext     (plaintext[g]),
      .out_valid     (out_valid[g]),
      .out_ready     (out_ready[g]),
      .done          (done[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic submit(input int d, input logic [127:0] c, input logic [127:0] k);
    @(negedge clk);
    chk("accept_ready", 128'(in_ready[d]), 128'd1);
    in_valid[d]   = 1'b1;
    ciphertext[d] = c;
    key[d]        = k;
    @(posedge clk);
    #1;
    in_valid[d]   = 1'b0;
    ciphertext[d] = rnd128();
    key[d]        = rnd128();
  endtask

  task automatic run_job(input int d, input logic [127:0] c, input logic [127:0] k,
                         input logic [127:0] pt, input bit miss, input int hold);
    int base, lat, ks, seqerr, rdyerr, holderr, step, exp_lat;
    logic [1:0] exp_mode;
    base    = miss ? 5 : 0;
    exp_lat = base + (NR + 1) * rc_of(d);
    lat = -1; ks = 0; seqerr = 0; rdyerr = 0; holderr = 0;
    submit(d, c, k);
    for (int j = 0; j < 400 && lat < 0; j++) begin
      @(negedge clk);
      if (out_valid[d]) lat = j;
      else begin
        if (key_start[d]) begin
          ks++;
          if (j != 0) seqerr++;
        end
        if (in_ready[d]) rdyerr++;
        if (j >= base) begin
          step     = (j - base) / rc_of(d);
          exp_mode = (step == 0) ? 2'd0 : (step == NR) ? 2'd2 : 2'd1;
          if (key_idx[d] !== 4'(NR - step)) seqerr++;
          if (rnd_mode[d] !== exp_mode) seqerr++;
        end
      end
    end
    chk("latency", 128'(lat), 128'(exp_lat));
    chk("key_start_count", 128'(ks), 128'(miss ? 1 : 0));
    chk("step_sequence_errs", 128'(seqerr), 128'd0);
    chk("busy_in_ready_errs", 128'(rdyerr), 128'd0);
    chk("plaintext", plaintext[d], pt);
    chk("done_eq_valid", 128'({done[d], out_valid[d]}), 128'd3);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (plaintext[d] !== pt || !out_valid[d] || in_ready[d]) holderr++;
    end
    chk("hold_errs", 128'(holderr), 128'd0);
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    @(negedge clk);
    chk("after_handshake", 128'({in_ready[d], out_valid[d]}), 128'b10);
  endtask

  task automatic abort_job(input int d, input logic [127:0] c, input logic [127:0] k,
                           input bit miss, input int at);
    int vseen, ks;
    vseen = 0; ks = 0;
    submit(d, c, k);
    for (int j = 0; j <= at; j++) begin
      @(negedge clk);
      if (out_valid[d]) vseen++;
      if (key_start[d]) ks++;
      if (j == at) abort[d] = 1'b1;
    end
    @(posedge clk);
    #1;
    abort[d] = 1'b0;
    @(negedge clk);
    chk("abort_to_idle", 128'({in_ready[d], out_valid[d]}), 128'b10);
    chk("abort_key_start", 128'(ks), 128'(miss ? 1 : 0));
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (out_valid[d]) vseen++;
    end
    chk("abort_no_valid", 128'(vseen), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] c1, k1, p1, k2, p2, c2, k, p, c;
    logic [127:0] ckey [2];
    bit           cvalid [2];
    bit           miss;
    logic [7:0]   inv, b;
    int           d;

    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = b;
      isbox[b] = 8'(x);
    end

    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      abort[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      ciphertext[i] = '0; key[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_key_q", key_q[0], 128'd0);
    chk("reset_rnd_state", rnd_state[0], 128'd0);
    chk("reset_plaintext", plaintext[0], 128'd0);
    chk("reset_ctl", 128'({in_ready[0], key_start[0], key_idx[0], rnd_mode[0], out_valid[0], done[0]}), 128'd0);
    rst = 1'b1;

    c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    k1 = 128'h000102030405060708090a0b0c0d0e0f;
    p1 = 128'h00112233445566778899aabbccddeeff;

    // Cold cache, then repeat with the same key.
    run_job(0, c1, k1, p1, 1'b1, 0);
    out_ready[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("stray_out_ready", 128'({in_ready[0], out_valid[0]}), 128'b10);
    out_ready[0] = 1'b0;
    run_job(0, c1, k1, p1, 1'b0, 0);

    // Three-cycle steps with a stalled consumer.
    run_job(1, c1, k1, p1, 1'b1, 5);

    // Abort mid-round keeps the key cache.
    abort_job(0, c1, k1, 1'b0, 5);
    run_job(0, c1, k1, p1, 1'b0, 0);

    // Abort during expansion invalidates the cache.
    k2 = rnd128();
    p2 = rnd128();
    c2 = encrypt(p2, k2);
    abort_job(0, c2, k2, 1'b1, 2);
    run_job(0, c2, k2, p2, 1'b1, 1);

    // Asynchronous reset in the middle of ROUND.
    submit(0, c2, k2);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_key_q", key_q[0], 128'd0);
    chk("midrst_rnd_state", rnd_state[0], 128'd0);
    chk("midrst_rnd_key", rnd_key[0], 128'd0);
    chk("midrst_plaintext", plaintext[0], 128'd0);
    chk("midrst_ctl", 128'({in_ready[0], key_start[0], key_idx[0], rnd_mode[0], out_valid[0], done[0]}), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    run_job(0, c2, k2, p2, 1'b1, 0);

    ckey[0] = k2; cvalid[0] = 1'b1;
    ckey[1] = '0; cvalid[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = i % 2;
      if (cvalid[d] && $urandom_range(1, 0) == 1) k = ckey[d];
      else k = rnd128();
      p    = rnd128();
      c    = encrypt(p, k);
      miss = !(cvalid[d] && (k == ckey[d]));
      run_job(d, c, k, p, miss, $urandom_range(3, 0));
      ckey[d]   = k;
      cvalid[d] = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
